// File: rtl/raster_text_pkg.sv
// Shared constants for the text-mode raster sequencer: character cell geometry,
// FSM state encoding and a counter-width helper.
package raster_text_pkg;

  localparam int CELL_W = 6;
  localparam int CELL_H = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_LOAD   = 3'd3;
  localparam logic [2:0] ST_ACTIVE = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  // Width of a counter holding values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/raster_text_addr_gen.sv
// Column / scan-row / text-row counters and the text RAM address adder.
// row_base accumulates COLS per text row so no multiplier is needed.
module raster_text_addr_gen
  import raster_text_pkg::*;
#(
  parameter int COLS   = 40,
  parameter int ROWS   = 25,
  parameter int ADDR_W = 10,
  parameter int COL_W  = cnt_w(COLS),
  parameter int TROW_W = cnt_w(ROWS + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_frame_start,
  input  logic              i_line_start,
  input  logic              i_col_inc,
  input  logic              i_line_end,
  output logic [COL_W-1:0]  o_col,
  output logic [2:0]        o_scan_row,
  output logic              o_rows_done,
  output logic [ADDR_W-1:0] o_addr
);

  logic [COL_W-1:0]  r_col;
  logic [2:0]        r_scan_row;
  logic [TROW_W-1:0] r_text_row;
  logic [ADDR_W-1:0] r_row_base;

  // NOTE: sequential state uses non-blocking assignments so every register in the
  // block samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col      <= '0;
      r_scan_row <= '0;
      r_text_row <= '0;
      r_row_base <= '0;
    end else begin
      if (i_frame_start) begin
        r_scan_row <= '0;
        r_text_row <= '0;
        r_row_base <= '0;
      end else if (i_line_end) begin
        r_scan_row <= r_scan_row + 3'd1;
        if (r_scan_row == 3'(CELL_H - 1)) begin
          r_text_row <= r_text_row + TROW_W'(1);
          r_row_base <= r_row_base + ADDR_W'(COLS);
        end
      end

      if (i_frame_start || i_line_start) begin
        r_col <= '0;
      end else if (i_col_inc) begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  assign o_col       = r_col;
  assign o_scan_row  = r_scan_row;
  assign o_rows_done = (r_text_row == TROW_W'(ROWS));
  assign o_addr      = r_row_base + ADDR_W'(r_col);

endmodule

// File: rtl/raster_text_sequencer.sv
// Walks text RAM along each active scan line, feeds the external font ROM and
// serialises 6-pixel rasters MSB first, prefetching the next cell while shifting.
module raster_text_sequencer
  import raster_text_pkg::*;
#(
  parameter int COLS   = 40,
  parameter int ROWS   = 25,
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_frame_start,
  input  logic              i_line_start,
  input  logic              i_pix_en,
  output logic [ADDR_W-1:0] o_txt_addr,
  output logic              o_txt_rd,
  input  logic [5:0]        i_txt_char,
  output logic [5:0]        o_font_char,
  output logic [3:0]        o_font_row,
  input  logic [5:0]        i_font_raster,
  output logic              o_pixel,
  output logic              o_pixel_valid,
  output logic              o_underrun
);

  localparam int COL_W = cnt_w(COLS);

  logic [2:0]       r_state;
  logic             r_txt_rd;
  logic             r_p1;        // text RAM data valid this clock
  logic             r_p2;        // font raster valid this clock
  logic [5:0]       r_font_char;
  logic [5:0]       r_next_buf;
  logic             r_nb_valid;
  logic [5:0]       r_shifter;
  logic [2:0]       r_px;
  logic [COL_W-1:0] r_slot;      // cell position currently being displayed
  logic             r_pixel;
  logic             r_pixel_valid;
  logic             r_underrun;

  logic [COL_W-1:0] w_col;
  logic [2:0]       w_scan_row;
  logic             w_rows_done;
  logic             w_restart;
  logic             w_in_line;
  logic             w_pix;
  logic             w_ready;
  logic [5:0]       w_raster;
  logic             w_cell_start;
  logic             w_load;
  logic             w_under;
  logic             w_last;
  logic             w_prefetch;
  logic             w_blank;

  raster_text_addr_gen #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_frame_start (i_frame_start),
    .i_line_start  (i_line_start),
    .i_col_inc     (w_prefetch),
    .i_line_end    (w_last),
    .o_col         (w_col),
    .o_scan_row    (w_scan_row),
    .o_rows_done   (w_rows_done),
    .o_addr        (o_txt_addr)
  );

  assign w_restart    = i_frame_start | i_line_start;
  assign w_in_line    = (r_state == ST_FETCH) || (r_state == ST_WAIT) ||
                        (r_state == ST_LOAD)  || (r_state == ST_ACTIVE);
  assign w_pix        = i_pix_en & w_in_line & ~w_restart;
  // A raster arriving from the font ROM this clock may be consumed directly.
  assign w_ready      = r_nb_valid | r_p2;
  assign w_raster     = r_nb_valid ? r_next_buf : i_font_raster;
  assign w_cell_start = (r_px == 3'd0);
  assign w_load       = w_pix & w_cell_start & w_ready;
  assign w_under      = w_pix & w_cell_start & ~w_ready;
  assign w_last       = w_pix & (r_px == 3'(CELL_W - 1)) & (r_slot == COL_W'(COLS - 1));
  assign w_prefetch   = w_load & (w_col != COL_W'(COLS - 1));
  // A simultaneous frame start rewinds the text row before the line begins.
  assign w_blank      = w_rows_done & ~i_frame_start;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_txt_rd      <= 1'b0;
      r_p1          <= 1'b0;
      r_p2          <= 1'b0;
      r_font_char   <= '0;
      r_next_buf    <= '0;
      r_nb_valid    <= 1'b0;
      r_shifter     <= '0;
      r_px          <= '0;
      r_slot        <= '0;
      r_pixel       <= 1'b0;
      r_pixel_valid <= 1'b0;
      r_underrun    <= 1'b0;
    end else if (w_restart) begin
      // Any in-flight fetch belongs to the aborted line and is discarded.
      r_p1          <= 1'b0;
      r_p2          <= 1'b0;
      r_nb_valid    <= 1'b0;
      r_shifter     <= '0;
      r_px          <= '0;
      r_slot        <= '0;
      r_pixel       <= 1'b0;
      r_pixel_valid <= 1'b0;
      if (i_frame_start) begin
        r_underrun <= 1'b0;
      end
      if (i_line_start && !w_blank) begin
        r_state  <= ST_FETCH;
        r_txt_rd <= 1'b1;
      end else begin
        r_state  <= i_line_start ? ST_DONE : ST_IDLE;
        r_txt_rd <= 1'b0;
      end
    end else begin
      r_txt_rd <= w_prefetch;
      r_p1     <= r_txt_rd;
      r_p2     <= r_p1;

      if (r_p1) begin
        r_font_char <= i_txt_char;
      end

      if (w_load) begin
        r_nb_valid <= 1'b0;
      end else if (r_p2) begin
        r_next_buf <= i_font_raster;
        r_nb_valid <= 1'b1;
      end

      if (w_under) begin
        r_underrun <= 1'b1;
      end

      r_pixel_valid <= w_pix;
      r_pixel       <= w_load ? w_raster[5] : (w_pix & ~w_under & r_shifter[5]);

      if (w_load) begin
        r_shifter <= {w_raster[4:0], 1'b0};
      end else if (w_under) begin
        r_shifter <= '0;
      end else if (w_pix) begin
        r_shifter <= {r_shifter[4:0], 1'b0};
      end

      if (w_pix) begin
        if (r_px == 3'(CELL_W - 1)) begin
          r_px <= '0;
          if (r_slot != COL_W'(COLS - 1)) begin
            r_slot <= r_slot + COL_W'(1);
          end
        end else begin
          r_px <= r_px + 3'd1;
        end
      end

      if (w_last) begin
        r_state <= ST_DONE;
      end else begin
        case (r_state)
          ST_FETCH: r_state <= ST_WAIT;
          ST_WAIT:  r_state <= ST_LOAD;
          ST_LOAD:  r_state <= ST_ACTIVE;
          default:  r_state <= r_state;
        endcase
      end
    end
  end

  assign o_txt_rd      = r_txt_rd;
  assign o_font_char   = r_font_char;
  assign o_font_row    = {1'b0, w_scan_row};
  assign o_pixel       = r_pixel;
  assign o_pixel_valid = r_pixel_valid;
  assign o_underrun    = r_underrun;

endmodule
